// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the execution units and the CDB arbiter.
// The master side belongs to the units and CDB consumers; the slave side belongs to the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
);
  logic [NUM_REQ-1:0]                    req_valid;
  logic [NUM_REQ-1:0]                    req_ready;
  logic [NUM_REQ-1:0][ROB_IDX_WIDTH-1:0] req_rob_idx;
  logic [NUM_REQ-1:0][4:0]               req_rd_addr;
  logic [NUM_REQ-1:0]                    req_regf_we;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_data;
  logic                                  flush;

  logic                                  cdb_valid;
  logic [ROB_IDX_WIDTH-1:0]              cdb_rob_idx;
  logic [4:0]                            cdb_rd_addr;
  logic                                  cdb_regf_we;
  logic [DATA_WIDTH-1:0]                 cdb_data;
  logic [CNT_WIDTH-1:0]                  conflict_cnt;

  modport master (
    output req_valid, req_rob_idx, req_rd_addr, req_regf_we, req_data, flush,
    input  req_ready, cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data,
           conflict_cnt
  );

  modport slave (
    input  req_valid, req_rob_idx, req_rd_addr, req_regf_we, req_data, flush,
    output req_ready, cdb_valid, cdb_rob_idx, cdb_rd_addr, cdb_regf_we, cdb_data,
           conflict_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single common-data-bus slot: grants one completed result
// per cycle, registers it onto the bus and counts cycles where units had to wait.
module cdb_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input logic           clk,
  input logic           rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]         r_rr_ptr;
  logic                     r_cdb_valid;
  logic [ROB_IDX_WIDTH-1:0] r_cdb_rob_idx;
  logic [4:0]               r_cdb_rd_addr;
  logic                     r_cdb_regf_we;
  logic [DATA_WIDTH-1:0]    r_cdb_data;
  logic [CNT_WIDTH-1:0]     r_conflict_cnt;

  logic [NUM_REQ-1:0]       w_grant;
  logic [PTR_W-1:0]         w_win_idx;
  logic                     w_found;
  logic                     w_xfer;
  logic                     w_conflict;

  // Search starts at the pointer and wraps, so the last winner has the lowest priority.
  always_comb begin : grant_search
    int               idx;
    logic [PTR_W-1:0] cand;
    // NOTE: every comb output gets a default up front so no path can infer a latch.
    w_found   = 1'b0;
    w_win_idx = '0;
    w_grant   = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!w_found && bus.req_valid[cand]) begin
        w_found   = 1'b1;
        w_win_idx = cand;
      end
    end
    if (w_found && !bus.flush && rst) w_grant[w_win_idx] = 1'b1;
  end

  assign w_xfer     = |w_grant;
  assign w_conflict = ($countones(bus.req_valid) >= 2) && !bus.flush;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr       <= '0;
      r_cdb_valid    <= 1'b0;
      r_cdb_rob_idx  <= '0;
      r_cdb_rd_addr  <= '0;
      r_cdb_regf_we  <= 1'b0;
      r_cdb_data     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (bus.flush) begin
        r_rr_ptr <= '0;
      end else if (w_xfer) begin
        r_rr_ptr <= (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
      end

      r_cdb_valid <= w_xfer;
      if (w_xfer) begin
        r_cdb_rob_idx <= bus.req_rob_idx[w_win_idx];
        r_cdb_rd_addr <= bus.req_rd_addr[w_win_idx];
        r_cdb_data    <= bus.req_data[w_win_idx];
        // Register 0 is hardwired, so a write to it must not reach the rename table.
        r_cdb_regf_we <= bus.req_regf_we[w_win_idx] && (bus.req_rd_addr[w_win_idx] != 5'd0);
      end

      if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.req_ready    = w_grant;
  assign bus.cdb_valid    = r_cdb_valid;
  assign bus.cdb_rob_idx  = r_cdb_rob_idx;
  assign bus.cdb_rd_addr  = r_cdb_rd_addr;
  assign bus.cdb_regf_we  = r_cdb_regf_we;
  assign bus.cdb_data     = r_cdb_data;
  assign bus.conflict_cnt = r_conflict_cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference round-robin model predicts each grant and
// queues the expected broadcast, which is popped and compared one cycle later.
module tb_cdb_arbiter;
  localparam int N = 4;

  typedef struct {
    logic        v;
    logic [4:0]  rob;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.NUM_REQ(N), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_WIDTH(5), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  int          m_ptr;
  logic [15:0] m_cnt;

  task automatic clear_inputs();
    bus.req_valid   = '0;
    bus.req_rob_idx = '0;
    bus.req_rd_addr = '0;
    bus.req_regf_we = '0;
    bus.req_data    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] u, input logic [4:0] rob, input logic [4:0] rd,
                         input logic we, input logic [31:0] data);
    bus.req_valid[u]   = 1'b1;
    bus.req_rob_idx[u] = rob;
    bus.req_rd_addr[u] = rd;
    bus.req_regf_we[u] = we;
    bus.req_data[u]    = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    m_ptr = 0;
    m_cnt = '0;
    q.delete();
  endtask

  // One clock cycle: predict grant, check ready, queue expected broadcast, then check bus.
  task automatic cycle();
    int         g;
    int         pc;
    logic       fl;
    logic [1:0] gi;
    logic [3:0] exp_ready;
    exp_t       e;
    exp_t       o;
    #1;
    g  = -1;
    fl = bus.flush;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        gi = 2'((m_ptr + k) % N);
        if (g < 0 && bus.req_valid[gi]) g = int'(gi);
      end
    end
    gi        = 2'(g < 0 ? 0 : g);
    exp_ready = (g >= 0) ? (4'b0001 << gi) : 4'b0000;
    checks++;
    if (bus.req_ready !== exp_ready) begin
      errors++;
      $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
    end
    e = '{v: 1'b0, rob: 5'd0, rd: 5'd0, we: 1'b0, data: 32'd0};
    if (g >= 0) begin
      e.v    = 1'b1;
      e.rob  = bus.req_rob_idx[gi];
      e.rd   = bus.req_rd_addr[gi];
      e.we   = bus.req_regf_we[gi] && (bus.req_rd_addr[gi] != 5'd0);
      e.data = bus.req_data[gi];
    end
    q.push_back(e);
    pc = $countones(bus.req_valid);
    @(posedge clk);
    if (fl) m_ptr = 0;
    else if (g >= 0) m_ptr = (g + 1) % N;
    if (!fl && pc >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    #1;
    o = q.pop_front();
    checks++;
    if (bus.cdb_valid !== o.v) begin
      errors++;
      $display("FAIL cdb_valid: got %b expected %b", bus.cdb_valid, o.v);
    end
    if (o.v) begin
      checks++;
      if ({bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data} !==
          {o.rob, o.rd, o.we, o.data}) begin
        errors++;
        $display("FAIL cdb_fields: got rob=%0d rd=%0d we=%b data=%h expected rob=%0d rd=%0d we=%b data=%h",
                 bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data,
                 o.rob, o.rd, o.we, o.data);
      end
    end
    checks++;
    if (bus.conflict_cnt !== m_cnt) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d expected %0d", bus.conflict_cnt, m_cnt);
    end
    @(negedge clk);
    if (g >= 0) bus.req_valid[gi] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.req_valid = 4'b1111;
    #12;
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data} !== '0) begin
      errors++;
      $display("FAIL reset_cdb: got valid=%b data=%h expected all zero", bus.cdb_valid, bus.cdb_data);
    end
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
    end
    checks++;
    if (bus.conflict_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", bus.conflict_cnt);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2'd1, 5'd7, 5'd5, 1'b1, 32'hDEADBEEF);
    cycle();
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data} !==
        {1'b1, 5'd7, 5'd5, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_bcast: got v=%b rob=%0d rd=%0d we=%b data=%h expected 1/7/5/1/deadbeef",
               bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data);
    end
    set_req(2'd0, 5'd1, 5'd1, 1'b1, 32'h1);
    set_req(2'd2, 5'd2, 5'd2, 1'b1, 32'h2);
    set_req(2'd3, 5'd3, 5'd3, 1'b1, 32'h3);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_ptr: got ready %b expected 0100", bus.req_ready);
    end
    repeat (4) cycle();
  endtask

  task automatic test_all_four();
    do_reset();
    for (int u = 0; u < N; u++) set_req(2'(u), 5'(10 + u), 5'(u + 1), 1'b1, 32'hA000_0000 + 32'(u));
    repeat (4) cycle();
    checks++;
    if (bus.conflict_cnt !== 16'd3) begin
      errors++;
      $display("FAIL all_four_cnt: got %0d expected 3", bus.conflict_cnt);
    end
    cycle();
  endtask

  task automatic test_fairness();
    do_reset();
    set_req(2'd2, 5'd4, 5'd4, 1'b1, 32'h44);
    cycle();
    set_req(2'd0, 5'd8, 5'd8, 1'b1, 32'h88);
    set_req(2'd2, 5'd9, 5'd9, 1'b1, 32'h99);
    cycle();
    cycle();
    checks++;
    if ({bus.cdb_rob_idx, bus.cdb_data} !== {5'd9, 32'h99}) begin
      errors++;
      $display("FAIL fairness_held: got rob=%0d data=%h expected 9/99", bus.cdb_rob_idx, bus.cdb_data);
    end
    cycle();
  endtask

  task automatic test_rd_zero();
    set_req(2'd0, 5'd3, 5'd0, 1'b1, 32'h1234);
    cycle();
    checks++;
    if ({bus.cdb_valid, bus.cdb_regf_we} !== 2'b10) begin
      errors++;
      $display("FAIL rd_zero: got valid=%b we=%b expected 1/0", bus.cdb_valid, bus.cdb_regf_we);
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    do_reset();
    set_req(2'd1, 5'd6, 5'd6, 1'b1, 32'h66);
    cycle();
    set_req(2'd0, 5'd11, 5'd11, 1'b1, 32'hB0);
    set_req(2'd3, 5'd13, 5'd13, 1'b1, 32'hB3);
    bus.flush  = 1'b1;
    cnt_before = bus.conflict_cnt;
    cycle();
    checks++;
    if ({bus.cdb_valid, bus.conflict_cnt} !== {1'b0, cnt_before}) begin
      errors++;
      $display("FAIL flush: got valid=%b cnt=%0d expected 0/%0d", bus.cdb_valid, bus.conflict_cnt, cnt_before);
    end
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    set_req(2'd1, 5'd21, 5'd21, 1'b1, 32'hC1);
    set_req(2'd3, 5'd23, 5'd23, 1'b1, 32'hC3);
    cycle();
    checks++;
    if (bus.cdb_rob_idx !== 5'd21) begin
      errors++;
      $display("FAIL flush_ptr: got rob=%0d expected 21", bus.cdb_rob_idx);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 80; c++) begin
      for (int u = 0; u < N; u++) begin
        if (!bus.req_valid[2'(u)] && ($urandom_range(0, 2) != 0))
          set_req(2'(u), 5'($urandom), 5'($urandom), 1'($urandom), $urandom);
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      cycle();
      if (bus.flush) begin
        bus.flush     = 1'b0;
        bus.req_valid = '0;
      end
    end
    bus.req_valid = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    set_req(2'd2, 5'd17, 5'd17, 1'b1, 32'hFACE);
    cycle();
    checks++;
    if (bus.cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got valid=%b expected 1", bus.cdb_valid);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_rd_addr, bus.cdb_regf_we, bus.cdb_data,
         bus.conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b data=%h cnt=%0d expected all zero",
               bus.cdb_valid, bus.cdb_data, bus.conflict_cnt);
    end
    do_reset();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.req_valid = 4'b1111;
    repeat (65536) @(posedge clk);
    #1;
    checks++;
    if (bus.conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: got %h expected ffff", bus.conflict_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.conflict_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h expected ffff", bus.conflict_cnt);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    m_ptr = 0;
    m_cnt = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_rd_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
